// File: rtl/gnrl_sgnl_pkg.sv
// Shared definitions for the general-signal pulse scheduler: FSM encoding and counter sizing.
package gnrl_sgnl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_WIDEN = 2'd2
    } sched_state_e;

    // One counter serves both phases, so it must hold the larger of the two terminal values.
    function automatic int cnt_width(input int dw, input int ww);
        return (dw > ww) ? dw : ww;
    endfunction

endpackage

// File: rtl/gnrl_sgnl_rr_arb.sv
// Request arbiter for the pulse scheduler: round-robin when GNRL_SGNL_PULSE_SCHED_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module gnrl_sgnl_rr_arb #(
    parameter int NCH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic                   accept,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx,
    output logic                   valid
);

    localparam int CW = $clog2(NCH);

`ifdef GNRL_SGNL_PULSE_SCHED_RR_EN
    logic [CW-1:0] ptr;
    int            cand;

    // Search begins at the pointer and wraps, so the channel after the last grant goes first.
    always_comb begin
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NCH; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NCH) cand = cand - NCH;
            if (!valid && req[cand[CW-1:0]]) begin
                valid   = 1'b1;
                gnt_idx = cand[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && valid) begin
            ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    logic unused_fp;
    assign unused_fp = ^{clk, rst_n, accept};

    always_comb begin
        gnt_idx = '0;
        valid   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid   = 1'b1;
                gnt_idx = CW'(i);
            end
        end
    end
`endif

    assign gnt = valid ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_idx) : '0;

endmodule

// File: rtl/gnrl_sgnl_pulse_sched.sv
// Multi-channel pulse scheduler sharing one delay/widen engine between NCH triggers.
// Arbitration policy selected by GNRL_SGNL_PULSE_SCHED_RR_EN (round-robin) or fixed priority.
module gnrl_sgnl_pulse_sched
    import gnrl_sgnl_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 12,
    parameter int WW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         trig_i,
    input  logic                   cfg_we,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [DW-1:0]          cfg_delay,
    input  logic [WW-1:0]          cfg_widen,
    output logic [NCH-1:0]         pulse_o,
    output logic                   busy_o,
    output logic [$clog2(NCH)-1:0] act_ch_o,
    output logic [NCH-1:0]         drop_o
);

    localparam int CW   = $clog2(NCH);
    localparam int CNTW = cnt_width(DW, WW);

    sched_state_e   state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [CW-1:0]   act_ch, act_nxt;
    logic [DW-1:0]   act_dly, act_dly_nxt;
    logic [WW-1:0]   act_wid, act_wid_nxt;

    logic [NCH-1:0]  trig_q;
    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  drop_q;
    logic [DW-1:0]   dly [NCH];
    logic [WW-1:0]   wid [NCH];

    logic [NCH-1:0]  arb_gnt;
    logic [CW-1:0]   arb_idx;
    logic            arb_valid;
    logic            take;
    logic [NCH-1:0]  trig_edge;
    logic [NCH-1:0]  grant_mask;

    assign trig_edge  = trig_i & ~trig_q;
    assign grant_mask = take ? arb_gnt : '0;

    gnrl_sgnl_rr_arb #(.NCH(NCH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (pend),
        .accept  (take),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    // A fresh edge beats a same-cycle grant; an edge onto an untaken pending bit is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= '0;
            pend   <= '0;
            drop_q <= '0;
        end else begin
            trig_q <= trig_i;
            pend   <= (pend & ~grant_mask) | trig_edge;
            drop_q <= trig_edge & pend & ~grant_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                dly[i] <= '0;
                wid[i] <= '0;
            end
        end else if (cfg_we) begin
            dly[cfg_ch] <= cfg_delay;
            wid[cfg_ch] <= cfg_widen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            act_ch  <= '0;
            act_dly <= '0;
            act_wid <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            act_ch  <= act_nxt;
            act_dly <= act_dly_nxt;
            act_wid <= act_wid_nxt;
        end
    end

    // Config is captured at grant so later writes cannot disturb a pulse in flight.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        act_nxt     = act_ch;
        act_dly_nxt = act_dly;
        act_wid_nxt = act_wid;
        take        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    take        = 1'b1;
                    act_nxt     = arb_idx;
                    act_dly_nxt = dly[arb_idx];
                    act_wid_nxt = wid[arb_idx];
                    cnt_nxt     = '0;
                    state_nxt   = (dly[arb_idx] == '0) ? ST_WIDEN : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (cnt == CNTW'(act_dly) - CNTW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WIDEN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WIDEN: begin
                if (cnt == CNTW'(act_wid)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pulse_o  = (state == ST_WIDEN) ? ({{(NCH-1){1'b0}}, 1'b1} << act_ch) : '0;
    assign busy_o   = (state != ST_IDLE);
    assign act_ch_o = act_ch;
    assign drop_o   = drop_q;

endmodule

// File: tb/tb_gnrl_sgnl_pulse_sched.sv
// Directed bench for gnrl_sgnl_pulse_sched; expectations follow GNRL_SGNL_PULSE_SCHED_RR_EN.
module tb_gnrl_sgnl_pulse_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  trig_i;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [11:0] cfg_delay;
    logic [3:0]  cfg_widen;
    logic [3:0]  pulse_o;
    logic        busy_o;
    logic [1:0]  act_ch_o;
    logic [3:0]  drop_o;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] trig;
        logic [3:0] exp_pulse;
        logic       exp_busy;
        logic [1:0] exp_act;
    } vec_t;

    vec_t vecs [12];

    gnrl_sgnl_pulse_sched #(.NCH(4), .DW(12), .WW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_i    (trig_i),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .cfg_widen (cfg_widen),
        .pulse_o   (pulse_o),
        .busy_o    (busy_o),
        .act_ch_o  (act_ch_o),
        .drop_o    (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [3:0] trig, input logic we, input logic [1:0] ch,
                                 input logic [11:0] d, input logic [3:0] w);
        trig_i    = trig;
        cfg_we    = we;
        cfg_ch    = ch;
        cfg_delay = d;
        cfg_widen = w;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ep, input logic eb,
                               input logic [1:0] ea, input logic ca, input logic [3:0] ed);
        n_cmp++;
        if (pulse_o !== ep || busy_o !== eb || drop_o !== ed || (ca && act_ch_o !== ea)) begin
            n_bad++;
            $display("[TB] FAIL %s: got pulse=%b busy=%b act=%0d drop=%b, want pulse=%b busy=%b act=%0d drop=%b",
                     name, pulse_o, busy_o, act_ch_o, drop_o, ep, eb, ea, ed);
        end
    endtask

    task automatic step(input logic [3:0] trig);
        applyStimulus(trig, 1'b0, 2'd0, 12'd0, 4'd0);
    endtask

    task automatic configure(input logic [1:0] ch, input logic [11:0] d, input logic [3:0] w);
        applyStimulus(4'b0000, 1'b1, ch, d, w);
    endtask

    task automatic expectIdle(input string name);
        checkOutput(name, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000);
    endtask

    task automatic expectBusy(input string name, input logic [3:0] ep, input logic [1:0] ea);
        checkOutput(name, ep, 1'b1, ea, 1'b1, 4'b0000);
    endtask

    task automatic doReset();
        rst_n  = 1'b0;
        trig_i = 4'b0000;
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset state", 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        trig_i    = 4'b0000;
        cfg_we    = 1'b0;
        cfg_ch    = 2'd0;
        cfg_delay = 12'd0;
        cfg_widen = 4'd0;
        rst_n     = 1'b0;

        // ch0 D=3 W=2 then ch1 D=0 W=0, one row per clock edge
        vecs[0]  = '{4'b0001, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[2]  = '{4'b0001, 4'b0000, 1'b1, 2'd0};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b1, 2'd0};
        vecs[4]  = '{4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[6]  = '{4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[8]  = '{4'b0010, 4'b0000, 1'b0, 2'd0};
        vecs[9]  = '{4'b0000, 4'b0010, 1'b1, 2'd1};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0, 2'd0};

        doReset();
        configure(2'd0, 12'd3, 4'd2);
        configure(2'd1, 12'd0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].trig);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_pulse, vecs[i].exp_busy,
                        vecs[i].exp_act, vecs[i].exp_busy, 4'b0000);
        end

        // Simultaneous ch0+ch2 with pointer at 0
        doReset();
        configure(2'd0, 12'd0, 4'd0);
        configure(2'd2, 12'd0, 4'd1);
        step(4'b0101); expectIdle("sim1 detect");
        step(4'b0000); expectBusy("sim1 first ch0", 4'b0001, 2'd0);
        step(4'b0000); expectIdle("sim1 gap");
        step(4'b0000); expectBusy("sim1 ch2 a", 4'b0100, 2'd2);
        step(4'b0000); expectBusy("sim1 ch2 b", 4'b0100, 2'd2);
        step(4'b0000); expectIdle("sim1 done");

        step(4'b0001); expectIdle("solo ch0 detect");
        step(4'b0000); expectBusy("solo ch0", 4'b0001, 2'd0);
        step(4'b0000); expectIdle("solo done");

        // Simultaneous again with pointer moved past ch0
        step(4'b0101); expectIdle("sim2 detect");
`ifdef GNRL_SGNL_PULSE_SCHED_RR_EN
        step(4'b0000); expectBusy("sim2 rr ch2 a", 4'b0100, 2'd2);
        step(4'b0000); expectBusy("sim2 rr ch2 b", 4'b0100, 2'd2);
        step(4'b0000); expectIdle("sim2 rr gap");
        step(4'b0000); expectBusy("sim2 rr ch0", 4'b0001, 2'd0);
`else
        step(4'b0000); expectBusy("sim2 fp ch0", 4'b0001, 2'd0);
        step(4'b0000); expectIdle("sim2 fp gap");
        step(4'b0000); expectBusy("sim2 fp ch2 a", 4'b0100, 2'd2);
        step(4'b0000); expectBusy("sim2 fp ch2 b", 4'b0100, 2'd2);
`endif
        step(4'b0000); expectIdle("sim2 done");

        // Three ch3 edges while ch1 is delaying
        configure(2'd1, 12'd10, 4'd0);
        configure(2'd3, 12'd0, 4'd0);
        step(4'b0010); expectIdle("drop ch1 detect");
        step(4'b0000); expectBusy("drop ch1 grant", 4'b0000, 2'd1);
        step(4'b1000); expectBusy("drop edge1", 4'b0000, 2'd1);
        step(4'b0000); expectBusy("drop gap1", 4'b0000, 2'd1);
        step(4'b1000); checkOutput("drop edge2", 4'b0000, 1'b1, 2'd1, 1'b1, 4'b1000);
        step(4'b0000); expectBusy("drop clear2", 4'b0000, 2'd1);
        step(4'b1000); checkOutput("drop edge3", 4'b0000, 1'b1, 2'd1, 1'b1, 4'b1000);
        step(4'b0000); expectBusy("drop clear3", 4'b0000, 2'd1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000); expectBusy($sformatf("drop ch1 delay%0d", i), 4'b0000, 2'd1);
        end
        step(4'b0000); expectBusy("drop ch1 pulse", 4'b0010, 2'd1);
        step(4'b0000); expectIdle("drop gap");
        step(4'b0000); expectBusy("drop ch3 pulse", 4'b1000, 2'd3);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000); expectIdle($sformatf("drop no second ch3 %0d", i));
        end

        // Config rewrite during DELAY does not affect the pulse in flight
        configure(2'd0, 12'd5, 4'd0);
        step(4'b0001); expectIdle("cfg detect");
        step(4'b0000); expectBusy("cfg grant", 4'b0000, 2'd0);
        configure(2'd0, 12'd1, 4'd0);
        expectBusy("cfg write in delay", 4'b0000, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000); expectBusy($sformatf("cfg old delay%0d", i), 4'b0000, 2'd0);
        end
        step(4'b0000); expectBusy("cfg old pulse", 4'b0001, 2'd0);
        step(4'b0000); expectIdle("cfg old done");
        step(4'b0001); expectIdle("cfg new detect");
        step(4'b0000); expectBusy("cfg new delay", 4'b0000, 2'd0);
        step(4'b0000); expectBusy("cfg new pulse", 4'b0001, 2'd0);
        step(4'b0000); expectIdle("cfg new done");

        // Reset asserted mid-WIDEN truncates the pulse immediately
        configure(2'd0, 12'd0, 4'd5);
        step(4'b0001); expectIdle("rst detect");
        step(4'b0000); expectBusy("rst pulse a", 4'b0001, 2'd0);
        step(4'b0000); expectBusy("rst pulse b", 4'b0001, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst async clear", 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(4'b0000); expectIdle($sformatf("rst no pulse%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
